// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster timing constants for the VGA timing generator.
//   - VGA640_*  : 640x480@60 (default timing, 25.175 MHz pixel clock)
//   - SVGA800_* : 800x600@60 preset (40 MHz pixel clock, positive syncs)
//   - max_int   : helper used for elaboration-time width checks
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // 640x480@60
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;
    localparam bit VGA640_HSYNC_POL = 1'b0;
    localparam bit VGA640_VSYNC_POL = 1'b0;
    localparam int VGA640_H_TOTAL  = VGA640_H_ACTIVE + VGA640_H_FRONT
                                   + VGA640_H_SYNC + VGA640_H_BACK;
    localparam int VGA640_V_TOTAL  = VGA640_V_ACTIVE + VGA640_V_FRONT
                                   + VGA640_V_SYNC + VGA640_V_BACK;

    // 800x600@60
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FRONT  = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BACK   = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FRONT  = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BACK   = 23;
    localparam bit SVGA800_HSYNC_POL = 1'b1;
    localparam bit SVGA800_VSYNC_POL = 1'b1;
    localparam int SVGA800_H_TOTAL  = SVGA800_H_ACTIVE + SVGA800_H_FRONT
                                    + SVGA800_H_SYNC + SVGA800_H_BACK;
    localparam int SVGA800_V_TOTAL  = SVGA800_V_ACTIVE + SVGA800_V_FRONT
                                    + SVGA800_V_SYNC + SVGA800_V_BACK;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0 .. TOTAL-1 while
// i_step is high and wraps to 0; any value >= TOTAL-1 also wraps, so an
// out-of-range count recovers on the next step.
//
// The decode outputs describe the count that will be loaded at the next
// edge, so the parent can register them alongside o_count and keep its
// flags aligned with the count with zero relative latency.
//
// Ports:
//   i_pixel_clk    pixel clock
//   i_reset        synchronous active-high reset (count -> TOTAL-1)
//   i_step         advance the count this cycle
//   o_count        registered count
//   o_wrap_next    current count is the last one; the next step wraps to 0
//   o_active       next count lies in the active region
//   o_sync_active  next count lies in the sync pulse region
// ---------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48,
    parameter int W      = 10
) (
    input  logic         i_pixel_clk,
    input  logic         i_reset,
    input  logic         i_step,
    output logic [W-1:0] o_count,
    output logic         o_wrap_next,
    output logic         o_active,
    output logic         o_sync_active
);

    localparam int TOTAL      = ACTIVE + FRONT + SYNC + BACK;
    localparam int SYNC_START = ACTIVE + FRONT;
    localparam int SYNC_END   = ACTIVE + FRONT + SYNC;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;

    // >= rather than == so a corrupted count still wraps.
    assign o_wrap_next = (r_count >= LAST);

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_count_next = r_count;
        if (i_step) begin
            if (o_wrap_next) begin
                w_count_next = '0;
            end else begin
                w_count_next = r_count + W'(1);
            end
        end
    end

    assign o_active      = (int'(w_count_next) < ACTIVE);
    assign o_sync_active = (int'(w_count_next) >= SYNC_START)
                        && (int'(w_count_next) < SYNC_END);

    always_ff @(posedge i_pixel_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            r_count <= LAST;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
// Raster timing for a single pixel-clock domain: horizontal/vertical counts,
// sync pulses, display enable, line/frame start strobes and a frame counter.
// All outputs are registered; decode flags are computed from the next count
// values and registered on the same edge as the counts.
//
// Ports:
//   i_pixel_clk     pixel clock
//   i_reset         synchronous active-high reset, priority over enable
//   i_enable        pixel-clock enable; everything holds while low
//   o_h_count       horizontal position
//   o_v_count       vertical position
//   o_hsync         horizontal sync, active level HSYNC_POL
//   o_vsync         vertical sync, active level VSYNC_POL
//   o_display_on    position is inside the visible area
//   o_line_start    one-cycle strobe when h_count becomes 0
//   o_frame_start   one-cycle strobe when position becomes (0,0)
//   o_frame_count   completed frames, wraps at 2^FC_W
// ---------------------------------------------------------------------------
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA640_H_ACTIVE,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int V_ACTIVE  = VGA640_V_ACTIVE,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter bit HSYNC_POL = VGA640_HSYNC_POL,
    parameter bit VSYNC_POL = VGA640_VSYNC_POL,
    parameter int CNT_W     = 10,
    parameter int FC_W      = 8
) (
    input  logic             i_pixel_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_h_count,
    output logic [CNT_W-1:0] o_v_count,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_display_on,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic [FC_W-1:0]  o_frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if ((1 << CNT_W) < max_int(H_TOTAL, V_TOTAL)) begin : g_cnt_w_check
        $error("vga_timing_generator: CNT_W too small for H_TOTAL/V_TOTAL");
    end

    logic w_h_wrap_next, w_h_active_next, w_h_sync_next;
    logic w_v_wrap_next, w_v_active_next, w_v_sync_next;
    logic w_v_step;
    logic w_frame_wrap;

    logic            r_hsync;
    logic            r_vsync;
    logic            r_display_on;
    logic            r_line_start;
    logic            r_frame_start;
    logic [FC_W-1:0] r_frame_count;
    logic            r_first_wrap;

    // The vertical axis moves only on the cycle the horizontal axis wraps.
    assign w_v_step     = i_enable & w_h_wrap_next;
    assign w_frame_wrap = w_v_step & w_v_wrap_next;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .W      (CNT_W)
    ) u_h_axis (
        .i_pixel_clk   (i_pixel_clk),
        .i_reset       (i_reset),
        .i_step        (i_enable),
        .o_count       (o_h_count),
        .o_wrap_next   (w_h_wrap_next),
        .o_active      (w_h_active_next),
        .o_sync_active (w_h_sync_next)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .W      (CNT_W)
    ) u_v_axis (
        .i_pixel_clk   (i_pixel_clk),
        .i_reset       (i_reset),
        .i_step        (w_v_step),
        .o_count       (o_v_count),
        .o_wrap_next   (w_v_wrap_next),
        .o_active      (w_v_active_next),
        .o_sync_active (w_v_sync_next)
    );

    always_ff @(posedge i_pixel_clk) begin
        if (i_reset) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
            r_first_wrap  <= 1'b1;
        end else begin
            // With enable low the next counts equal the current ones, so
            // the decoded flags hold naturally while the strobes drop.
            r_hsync       <= w_h_sync_next ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_v_sync_next ? VSYNC_POL : ~VSYNC_POL;
            r_display_on  <= w_h_active_next & w_v_active_next;
            r_line_start  <= i_enable & w_h_wrap_next;
            r_frame_start <= w_frame_wrap;
            // The wrap out of the reset position is not a completed frame.
            if (w_frame_wrap) begin
                if (r_first_wrap) begin
                    r_first_wrap <= 1'b0;
                end else begin
                    r_frame_count <= r_frame_count + FC_W'(1);
                end
            end
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_display_on  = r_display_on;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
// Two instances share reset/enable: the default 640x480 timing (dut0) and a
// tiny override (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1, CNT_W=3) (dut1).
// The driver pushes expected output vectors into a scoreboard queue after
// every edge (from a position-from-step-count reference model, plus
// hand-computed spot vectors); a monitor pops and compares on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] h0, v0;
    logic       hs0, vs0, de0, ls0, fs0;
    logic [7:0] fc0;

    logic [2:0] h1, v1;
    logic       hs1, vs1, de1, ls1, fs1;
    logic [7:0] fc1;

    vga_timing_generator u_dut0 (
        .i_pixel_clk   (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .o_h_count     (h0),
        .o_v_count     (v0),
        .o_hsync       (hs0),
        .o_vsync       (vs0),
        .o_display_on  (de0),
        .o_line_start  (ls0),
        .o_frame_start (fs0),
        .o_frame_count (fc0)
    );

    vga_timing_generator #(
        .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0),
        .CNT_W (3), .FC_W (8)
    ) u_dut1 (
        .i_pixel_clk   (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .o_h_count     (h1),
        .o_v_count     (v1),
        .o_hsync       (hs1),
        .o_vsync       (vs1),
        .o_display_on  (de1),
        .o_line_start  (ls1),
        .o_frame_start (fs1),
        .o_frame_count (fc1)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    typedef struct {
        string name;
        int    dut;
        exp_t  e;
    } sb_t;

    sb_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  n     = 0;    // enabled edges since last reset
    bit  adv   = 1'b0; // last edge advanced the raster

    // Position is derived from the number of enabled edges since reset:
    // the first enabled edge lands on (0,0).
    function automatic exp_t model(input int steps, input bit advanced,
                                   input int ha, input int hf, input int hw, input int hb,
                                   input int va, input int vf, input int vw, input int vb,
                                   input bit hpol, input bit vpol);
        exp_t e;
        int ht, vt, p, h, v;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        if (steps == 0) begin
            e.h  = 10'(ht - 1);
            e.v  = 10'(vt - 1);
            e.hs = ~hpol;
            e.vs = ~vpol;
            e.de = 1'b0;
            e.ls = 1'b0;
            e.fs = 1'b0;
            e.fc = 8'd0;
        end else begin
            p    = (steps - 1) % (ht * vt);
            h    = p % ht;
            v    = p / ht;
            e.h  = 10'(h);
            e.v  = 10'(v);
            e.hs = (h >= ha + hf && h < ha + hf + hw) ? hpol : ~hpol;
            e.vs = (v >= va + vf && v < va + vf + vw) ? vpol : ~vpol;
            e.de = (h < ha) && (v < va);
            e.ls = advanced && (h == 0);
            e.fs = advanced && (h == 0) && (v == 0);
            e.fc = 8'(((steps - 1) / (ht * vt)) % 256);
        end
        return e;
    endfunction

    task automatic push_model();
        sb_t s;
        s.name = $sformatf("model_n%0d", n);
        s.dut  = 0;
        s.e    = model(n, adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        sb.push_back(s);
        s.dut  = 1;
        s.e    = model(n, adv, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0);
        sb.push_back(s);
    endtask

    task automatic step(input bit r, input bit e);
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            n   = 0;
            adv = 1'b0;
        end else if (e) begin
            n   = n + 1;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        push_model();
    endtask

    task automatic run_to(input int target);
        while (n < target) step(1'b0, 1'b1);
    endtask

    task automatic spot(input string name, input int dut, input int h, input int v,
                        input bit hs, input bit vs, input bit de, input bit ls,
                        input bit fs, input int fc);
        sb_t s;
        s.name = name;
        s.dut  = dut;
        s.e    = '{h: 10'(h), v: 10'(v), hs: hs, vs: vs, de: de, ls: ls, fs: fs, fc: 8'(fc)};
        sb.push_back(s);
    endtask

    // Monitor: compares every queued expectation against the sampled outputs.
    initial begin
        sb_t  s;
        exp_t a;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                s = sb.pop_front();
                if (s.dut == 0) a = {h0, v0, hs0, vs0, de0, ls0, fs0, fc0};
                else            a = {7'd0, h1, 7'd0, v1, hs1, vs1, de1, ls1, fs1, fc1};
                tests++;
                if (a !== s.e) begin
                    fails++;
                    $display("FAIL %s dut%0d: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                             s.name, s.dut, a.h, a.v, a.hs, a.vs, a.de, a.ls, a.fs, a.fc,
                             s.e.h, s.e.v, s.e.hs, s.e.vs, s.e.de, s.e.ls, s.e.fs, s.e.fc);
                end
            end
        end
    end

    initial begin
        // Reset held three cycles with enable high.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        spot("reset0", 0, 799, 524, 1, 1, 0, 0, 0, 0);
        spot("reset1", 1, 7, 5, 0, 1, 0, 0, 0, 0);

        step(1'b0, 1'b1);
        spot("first_edge0", 0, 0, 0, 1, 1, 1, 1, 1, 0);
        spot("first_edge1", 1, 0, 0, 0, 1, 1, 1, 1, 0);

        // Horizontal boundaries on the default timing.
        run_to(640);  spot("h639_active", 0, 639, 0, 1, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1); spot("h640_blank", 0, 640, 0, 1, 1, 0, 0, 0, 0);
        run_to(656);  spot("h655_nosync", 0, 655, 0, 1, 1, 0, 0, 0, 0);
        step(1'b0, 1'b1); spot("h656_sync", 0, 656, 0, 0, 1, 0, 0, 0, 0);
        run_to(752);  spot("h751_sync", 0, 751, 0, 0, 1, 0, 0, 0, 0);
        step(1'b0, 1'b1); spot("h752_nosync", 0, 752, 0, 1, 1, 0, 0, 0, 0);
        run_to(800);  spot("h799_last", 0, 799, 0, 1, 1, 0, 0, 0, 0);

        // Enable 0,0,1 around the line wrap.
        step(1'b0, 1'b0); spot("hold_a", 0, 799, 0, 1, 1, 0, 0, 0, 0);
        step(1'b0, 1'b0); spot("hold_b", 0, 799, 0, 1, 1, 0, 0, 0, 0);
        step(1'b0, 1'b1); spot("line_wrap", 0, 0, 1, 1, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1); spot("line_strobe_drop", 0, 1, 1, 1, 1, 1, 0, 0, 0);

        // Reset mid-frame.
        run_to(1101); spot("mid_frame", 0, 300, 1, 1, 1, 1, 0, 0, 0);
        step(1'b1, 1'b1);
        spot("mid_reset0", 0, 799, 524, 1, 1, 0, 0, 0, 0);
        spot("mid_reset1", 1, 7, 5, 0, 1, 0, 0, 0, 0);

        // Small timing: full frames, sync windows, frame counter wrap.
        step(1'b0, 1'b1);
        run_to(48);   spot("s_last_pos", 1, 7, 5, 0, 1, 0, 0, 0, 0);
        step(1'b0, 1'b1); spot("s_frame1", 1, 0, 0, 0, 1, 1, 1, 1, 1);
        run_to(53);   spot("s_h4", 1, 4, 0, 0, 1, 0, 0, 0, 1);
        step(1'b0, 1'b1); spot("s_h5_sync", 1, 5, 0, 1, 1, 0, 0, 0, 1);
        step(1'b0, 1'b1); spot("s_h6_sync", 1, 6, 0, 1, 1, 0, 0, 0, 1);
        step(1'b0, 1'b1); spot("s_h7_nosync", 1, 7, 0, 0, 1, 0, 0, 0, 1);
        run_to(80);   spot("s_v3_novsync", 1, 7, 3, 0, 1, 0, 0, 0, 1);
        step(1'b0, 1'b1); spot("s_v4_vsync", 1, 0, 4, 0, 0, 0, 1, 0, 1);
        run_to(88);   spot("s_v4_end", 1, 7, 4, 0, 0, 0, 0, 0, 1);
        step(1'b0, 1'b1); spot("s_v5_novsync", 1, 0, 5, 0, 1, 0, 1, 0, 1);
        run_to(12288); spot("s_fc255", 1, 7, 5, 0, 1, 0, 0, 0, 255);
        step(1'b0, 1'b1); spot("s_fc_wrap", 1, 0, 0, 0, 1, 1, 1, 1, 0);

        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised successor to the single-axis vertical pixel counter.
- Generates both horizontal and vertical raster counts, sync pulses, display-enable, line/frame start strobes and a frame counter.
- Sits between the pixel clock domain and all sprite/background renderers, which consume the counts and the display_on flag.
- All timing (active, porches, sync width, polarity) is parametrised; defaults give 640x480@60.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level
- CNT_W, 10, width of h_count/v_count
- FC_W, 8, width of frame_count

Ports:
- pixel_clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  pixel-clock enable; counts advance only when high
- h_count  output  CNT_W  current horizontal position
- v_count  output  CNT_W  current vertical position
- hsync  output  1  horizontal sync, level per HSYNC_POL
- vsync  output  1  vertical sync, level per VSYNC_POL
- display_on  output  1  high when position is in the active area
- line_start  output  1  one-cycle strobe when h_count becomes 0
- frame_start  output  1  one-cycle strobe when position becomes (0,0)
- frame_count  output  FC_W  completed-frame counter, wraps at 2^FC_W

Behaviour:
- Interface: one clock, pixel_clk; reset is synchronous and active-high; all outputs are registered.
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Elaboration error if 2^CNT_W < max(H_TOTAL, V_TOTAL).
- Reset state (takes effect at the pixel_clk edge with reset=1):
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1 (last back-porch position)
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL
  - display_on = 0, line_start = 0, frame_start = 0, frame_count = 0
- Reset has priority over enable. Reset mid-frame returns immediately to the reset state.
- Advance (enable=1):
  - If h_count >= H_TOTAL-1: h_count <= 0.
    - If also v_count >= V_TOTAL-1: v_count <= 0 and frame_count <= frame_count+1; otherwise v_count <= v_count+1.
  - Otherwise: h_count <= h_count+1, v_count held.
  - The >= compare also recovers from out-of-range values.
- Consequence: the first enabled cycle after reset yields (0,0) with frame_start=1 and line_start=1. frame_count stays 0 on that first wrap out of reset; it increments on every later (V_TOTAL-1) -> 0 wrap.
- Decode: computed from the next count values and registered in the same edge, so decode outputs are always consistent with the displayed h_count/v_count (zero relative latency).
  - display_on = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync active iff H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC
  - vsync active iff V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC; vsync changes only at h wrap
- enable=0: counts, hsync, vsync, display_on and frame_count are held.
  - line_start and frame_start deassert next edge; strobes are never longer than one cycle.
- Simultaneous h and v wrap: line_start and frame_start both asserted on the same cycle.

Decomposition:
- Package vga_timing_pkg: default 640x480 timing constants and derived totals. Optional 800x600 preset constants.
- Sub-module vga_axis_counter (instantiated twice, h and v):
  - Parameters: ACTIVE/FRONT/SYNC/BACK/W.
  - Inputs: pixel_clk, reset, step.
  - Outputs: count, wrap_next, active, sync_active.
  - The h instance's wrap_next gates the v instance's step.

Test Plan:
- Reset held 3 cycles, enable=1 -> h_count=799, v_count=524, hsync=vsync=1, display_on=0, strobes 0. First edge after release -> (0,0), display_on=1, frame_start=1, line_start=1.
- Run from (0,0): at h=639 display_on=1; h=640 display_on=0; hsync=0 for h=656..751, 1 at h=752; at h=799 -> 0 with v=1 and line_start=1, frame_start=0.
- Run full frame: vsync=0 exactly for v=490..491 (1600 enabled cycles). Wrap (799,524) -> (0,0) with frame_start=1 and frame_count 0->1. After 256 more frames, frame_count wraps to 0.
- enable toggled 1,0,0,1 around h=799: counts hold during the 0 cycles; line_start is high for one cycle only.
- Assert reset at (300,200) -> next edge h=799, v=524, frame_count=0, outputs at reset values.
- Small timing override (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1): hsync=1 only at h=5..6; V_TOTAL=6 frames of 48 cycles; output of the full sequence matches a reference model.
